serial_adder_ctrl: RTL

- Bit-serial N-bit adder front end. Sits directly upstream of the single-bit full-adder cell and drives its a, b and carry-in inputs one bit per clock, LSB first.
- Holds the cell's carry-out in a carry flip-flop and shifts each sum bit into a result register.
- Presents a start/busy/done handshake to the surrounding datapath, so a multi-bit add costs WIDTH cycles on one full-adder cell.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_adder_ctrl_fa_cell.sv | 17 +
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder front end.
// Contents: FSM state encoding and the bit-counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One bit wider than $clog2 so the counter can hold WIDTH after the last shift
  // and a WIDTH=1 build still gets a 1-bit counter.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational single-bit full adder.
// Ports:
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   co        : carry-out (majority of a, b, cin)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: feeds one full-adder cell LSB first,
// keeps the running carry in a flip-flop and shifts sum bits in from the top.
// Ports:
//   clk, rst_n       : clock and synchronous active-low reset
//   start            : request, honoured only in IDLE or DONE
//   a_in, b_in, cin_in : operands, captured on the accepting edge
//   busy             : high while bits are being shifted
//   done             : one-cycle pulse when sum/cout become valid
//   sum, cout        : result, held until the next accepted start
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for start, result registers hold
// ST_SHIFT | one sum bit per edge, WIDTH edges total
// ST_DONE  | result valid, done pulse; start may re-launch
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          carry <= fa_co;
          // New bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB.
          sum   <= (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            cout  <= fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
